// File: rtl/phase_slot_sequencer_if.sv
// Bus between the phase slot sequencer and its environment: the phase memory
// port, the per-slot frequency controls and the phase output to the operator stage.
interface phase_slot_sequencer_if #(
  parameter int PHASE_W = 18,
  parameter int PG_W    = 9
);
  logic               clkena;
  logic [8:0]         fnum;
  logic [2:0]         blk;
  logic [3:0]         ml;
  logic               key_trig;
  logic [4:0]         slot_out;
  logic               memwr;
  logic [PHASE_W-1:0] memwdata;
  logic [PHASE_W-1:0] memrdata;
  logic [PG_W-1:0]    pgout;
  logic               pg_valid;
  logic [4:0]         pg_slot;

  modport master (
    input  clkena, fnum, blk, ml, key_trig, memrdata,
    output slot_out, memwr, memwdata, pgout, pg_valid, pg_slot
  );

  modport slave (
    output clkena, fnum, blk, ml, key_trig, memrdata,
    input  slot_out, memwr, memwdata, pgout, pg_valid, pg_slot
  );
endinterface

// File: rtl/phase_slot_sequencer.sv
// Steps through the phase memory slots, reads each stored phase, adds the
// increment derived from fnum/blk/ml and writes the result back.
module phase_slot_sequencer #(
  parameter int NSLOTS  = 18,
  parameter int PHASE_W = 18,
  parameter int PG_W    = 9
) (
  input logic clk,
  input logic reset,
  phase_slot_sequencer_if.master bus
);

  localparam int SLOT_W = 5;

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {RD, WR} stage_t;

  state_t              state;
  stage_t              stage;
  logic [SLOT_W-1:0]   init_cnt;
  logic [SLOT_W-1:0]   slot_q;
  logic [PG_W-1:0]     pgout_q;
  logic                pg_valid_q;
  logic [SLOT_W-1:0]   pg_slot_q;

  logic [4:0]          mul2;
  logic [20:0]         shifted;
  logic [20:0]         product;
  logic [PHASE_W-1:0]  incr;
  logic [PHASE_W-1:0]  next_phase;
  logic                write_step;

  // mul2 is twice the frequency multiple, so ml=0 still encodes x0.5
  always_comb begin
    mul2 = 5'd1;
    case (bus.ml)
      4'd0:  mul2 = 5'd1;
      4'd1:  mul2 = 5'd2;
      4'd2:  mul2 = 5'd4;
      4'd3:  mul2 = 5'd6;
      4'd4:  mul2 = 5'd8;
      4'd5:  mul2 = 5'd10;
      4'd6:  mul2 = 5'd12;
      4'd7:  mul2 = 5'd14;
      4'd8:  mul2 = 5'd16;
      4'd9:  mul2 = 5'd18;
      4'd10: mul2 = 5'd20;
      4'd11: mul2 = 5'd20;
      4'd12: mul2 = 5'd24;
      4'd13: mul2 = 5'd24;
      4'd14: mul2 = 5'd30;
      default: mul2 = 5'd30;
    endcase
  end

  always_comb begin
    shifted    = 21'(bus.fnum) << bus.blk;
    product    = shifted * 21'(mul2);
    incr       = PHASE_W'(product >> 1);
    next_phase = bus.key_trig ? '0 : bus.memrdata + incr;
  end

  // Write strobe is combinational so a reset or a clkena stall drops it at once
  assign write_step   = (state == RUN) && (stage == WR);
  assign bus.memwr    = write_step && bus.clkena;
  assign bus.memwdata = write_step ? next_phase : '0;
  assign bus.slot_out = slot_q;
  assign bus.pgout    = pgout_q;
  assign bus.pg_valid = pg_valid_q;
  assign bus.pg_slot  = pg_slot_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      stage      <= RD;
      init_cnt   <= '0;
      slot_q     <= '0;
      pgout_q    <= '0;
      pg_valid_q <= 1'b0;
      pg_slot_q  <= '0;
    end else begin
      pg_valid_q <= 1'b0;
      case (state)
        INIT: begin
          // The memory is clearing itself here, so time it with every edge
          init_cnt <= init_cnt + SLOT_W'(1);
          if (init_cnt == SLOT_W'(NSLOTS - 1)) begin
            state  <= RUN;
            stage  <= RD;
            slot_q <= '0;
          end
        end
        RUN: begin
          if (bus.clkena) begin
            if (stage == RD) begin
              stage <= WR;
            end else begin
              pgout_q    <= next_phase[PHASE_W-1 -: PG_W];
              pg_slot_q  <= slot_q;
              pg_valid_q <= 1'b1;
              stage      <= RD;
              slot_q     <= (slot_q == SLOT_W'(NSLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_slot_sequencer.sv
// Drives the sequencer against a behavioural phase memory and checks every
// cycle against a slot-indexed reference of the stored phases.
module tb_phase_slot_sequencer;

  localparam int NSLOTS  = 18;
  localparam int PHASE_W = 18;
  localparam int PG_W    = 9;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  phase_slot_sequencer_if #(.PHASE_W(PHASE_W), .PG_W(PG_W)) bus ();

  phase_slot_sequencer #(.NSLOTS(NSLOTS), .PHASE_W(PHASE_W), .PG_W(PG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Phase memory: clears one slot per clock after reset, registered read
  logic [PHASE_W-1:0] mem [NSLOTS];
  logic [4:0]         clr_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt      <= '0;
      bus.memrdata <= '0;
    end else begin
      if (clr_cnt < 5'(NSLOTS)) begin
        mem[clr_cnt] <= '0;
        clr_cnt      <= clr_cnt + 5'd1;
      end else if (bus.memwr) begin
        mem[bus.slot_out] <= bus.memwdata;
      end
      bus.memrdata <= mem[bus.slot_out];
    end
  end

  int checks   = 0;
  int failures = 0;

  int                 init_left;
  int                 k;
  int                 dut_writes;
  logic [PHASE_W-1:0] ref_phase [NSLOTS];
  logic [PG_W-1:0]    exp_pgout;
  logic               exp_pg_valid;
  logic [4:0]         exp_pg_slot;
  logic [PHASE_W-1:0] last_wr_data;
  int                 wr_before;
  int                 mul2 [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

  function automatic int expected_phase(int cur, int f, int b, int m, bit kt);
    int incr;
    if (kt) return 0;
    incr = ((f * (1 << b)) * mul2[m]) / 2;
    return (cur + incr) % (1 << PHASE_W);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_slot_out", 32'(bus.slot_out), 0);
    checkOutput("rst_memwr",    32'(bus.memwr),    0);
    checkOutput("rst_memwdata", 32'(bus.memwdata), 0);
    checkOutput("rst_pgout",    32'(bus.pgout),    0);
    checkOutput("rst_pg_valid", 32'(bus.pg_valid), 0);
    checkOutput("rst_pg_slot",  32'(bus.pg_slot),  0);
  endtask

  task automatic modelReset();
    init_left    = NSLOTS;
    k            = 0;
    dut_writes   = 0;
    exp_pgout    = '0;
    exp_pg_valid = 1'b0;
    exp_pg_slot  = '0;
    foreach (ref_phase[i]) ref_phase[i] = '0;
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model
  task automatic applyStimulus(input bit ce, input int f, input int b, input int m, input bit kt);
    int slot;
    bit in_run;
    bit wr_step;
    int nxt;
    @(negedge clk);
    bus.clkena   = ce;
    bus.fnum     = 9'(f);
    bus.blk      = 3'(b);
    bus.ml       = 4'(m);
    bus.key_trig = kt;
    #1;
    in_run  = (init_left == 0);
    slot    = in_run ? (k / 2) % NSLOTS : 0;
    wr_step = in_run && (k % 2 == 1);
    nxt     = expected_phase(int'(ref_phase[slot]), f, b, m, kt);
    checkOutput("slot_out", 32'(bus.slot_out), slot);
    checkOutput("memwr",    32'(bus.memwr),    32'(wr_step && ce));
    if (wr_step) checkOutput("memwdata", 32'(bus.memwdata), nxt);
    checkOutput("pg_valid", 32'(bus.pg_valid), 32'(exp_pg_valid));
    checkOutput("pgout",    32'(bus.pgout),    32'(exp_pgout));
    checkOutput("pg_slot",  32'(bus.pg_slot),  32'(exp_pg_slot));
    if (bus.memwr === 1'b1) begin
      dut_writes++;
      last_wr_data = bus.memwdata;
    end
    @(posedge clk);
    exp_pg_valid = 1'b0;
    if (!in_run) begin
      init_left--;
    end else if (ce) begin
      if (wr_step) begin
        ref_phase[slot] = PHASE_W'(nxt);
        exp_pgout       = ref_phase[slot][PHASE_W-1 -: PG_W];
        exp_pg_slot     = 5'(slot);
        exp_pg_valid    = 1'b1;
      end
      k++;
    end
  endtask

  task automatic randomStep(input bit ce, input bit kt);
    applyStimulus(ce, int'($urandom_range(0, 511)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), kt);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetOutputs();
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.clkena   = 1'b0;
    bus.fnum     = '0;
    bus.blk      = '0;
    bus.ml       = '0;
    bus.key_trig = 1'b0;
    reset        = 1'b0;
    modelReset();
    #1 reset = 1'b1;
    #11;
    checkResetOutputs();
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] INIT window and constant increment 1024");
    repeat (NSLOTS) applyStimulus(1'b1, 256, 2, 1, 1'b0);
    checkOutput("init_no_writes", 32'(dut_writes), 0);
    repeat (2 * NSLOTS) applyStimulus(1'b1, 256, 2, 1, 1'b0);
    #1;
    checkOutput("f1_wdata",  32'(last_wr_data), 1024);
    checkOutput("f1_pgout",  32'(bus.pgout),    2);
    checkOutput("f1_pgslot", 32'(bus.pg_slot),  17);
    checkOutput("f1_writes", 32'(dut_writes),   18);
    repeat (2 * NSLOTS) applyStimulus(1'b1, 256, 2, 1, 1'b0);
    #1;
    checkOutput("f2_wdata", 32'(last_wr_data), 2048);
    checkOutput("f2_pgout", 32'(bus.pgout),    4);

    $display("[TB] half multiple with truncation");
    doReset();
    repeat (NSLOTS + 2 * NSLOTS) applyStimulus(1'b1, 3, 0, 0, 1'b0);
    #1;
    checkOutput("half_f1_wdata", 32'(last_wr_data), 1);
    repeat (2 * NSLOTS) applyStimulus(1'b1, 3, 0, 0, 1'b0);
    #1;
    checkOutput("half_f2_wdata", 32'(last_wr_data), 2);

    $display("[TB] maximum increment and wrap");
    doReset();
    repeat (NSLOTS + 2 * NSLOTS) applyStimulus(1'b1, 511, 7, 15, 1'b0);
    #1;
    checkOutput("max_f1_wdata", 32'(last_wr_data), 194688);
    checkOutput("max_f1_pgout", 32'(bus.pgout),    380);
    repeat (2 * NSLOTS) applyStimulus(1'b1, 511, 7, 15, 1'b0);
    #1;
    checkOutput("max_f2_wdata", 32'(last_wr_data), 127232);
    checkOutput("max_f2_pgout", 32'(bus.pgout),    248);

    $display("[TB] random controls with clkena gaps");
    for (int i = 0; i < 200; i++) begin
      randomStep($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] key restart on slot 5");
    for (int i = 0; i < 80 && (k % (2 * NSLOTS)) != 11; i++) randomStep(1'b1, 1'b0);
    randomStep(1'b1, 1'b1);
    #1;
    checkOutput("key_wdata",  32'(last_wr_data), 0);
    checkOutput("key_pgout",  32'(bus.pgout),    0);
    checkOutput("key_pgslot", 32'(bus.pg_slot),  5);
    repeat (2 * NSLOTS) randomStep(1'b1, 1'b0);

    $display("[TB] seven-clock stall inside a write step");
    for (int i = 0; i < 4 && (k % 2) == 0; i++) randomStep(1'b1, 1'b0);
    wr_before = dut_writes;
    repeat (7) applyStimulus(1'b0, 100, 3, 5, 1'b0);
    applyStimulus(1'b1, 100, 3, 5, 1'b0);
    checkOutput("stall_writes", 32'(dut_writes - wr_before), 1);

    $display("[TB] reset in the middle of a write step");
    repeat (5) randomStep(1'b1, 1'b0);
    for (int i = 0; i < 4 && (k % 2) == 0; i++) randomStep(1'b1, 1'b0);
    @(negedge clk);
    bus.clkena = 1'b1;
    #1;
    checkOutput("pre_reset_memwr", 32'(bus.memwr), 1);
    reset = 1'b1;
    #1;
    checkResetOutputs();
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (NSLOTS) randomStep(1'b1, 1'b0);
    checkOutput("reinit_no_writes", 32'(dut_writes), 0);
    repeat (4) randomStep(1'b1, 1'b0);
    checkOutput("reinit_writes", 32'(dut_writes), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_slot_sequencer.md
Name: phase_slot_sequencer

Overview:
- Client-side master for the 18-slot phase memory: steps the slot address, reads each slot's stored phase, and adds the frequency increment derived from fnum/blk/ml.
- Writes the updated phase back and presents the top phase bits to the operator stage.
- Owns all address, write-enable and write-data timing toward the memory; the memory holds state only.

Parameters:
- NSLOTS, 18, slots per frame; must match the memory depth.
- PHASE_W, 18, phase accumulator width (PHASE_TYPE).
- PG_W, 9, width of the phase output to the operator, taken as phase[PHASE_W-1 -: PG_W].

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clkena  in  1  advance enable; the sequencer steps only on clk edges with clkena=1.
- fnum  in  9  F-number for the slot on slot_out; sampled in the write cycle.
- blk  in  3  block (octave) for the slot on slot_out; sampled in the write cycle.
- ml  in  4  multiple code for the slot on slot_out; sampled in the write cycle.
- key_trig  in  1  phase restart for the slot on slot_out; sampled in the write cycle.
- slot_out  out  5  slot address to the memory's slot input.
- memwr  out  1  write strobe to the memory.
- memwdata  out  PHASE_W  data to the memory's memin.
- memrdata  in  PHASE_W  data from the memory's memout (registered; 1-clk read latency).
- pgout  out  PG_W  upper phase bits of the value just written.
- pg_valid  out  1  one-clk pulse; pgout and pg_slot are valid.
- pg_slot  out  5  slot that pgout belongs to.

Behaviour:
- Reset values: slot_out=0, memwr=0, memwdata=0, pgout=0, pg_valid=0, pg_slot=0; state=INIT, init_cnt=0, stage=RD.
- Reset mid-operation aborts any pending write; memwr drops immediately (async). The memory shares the reset and re-clears.
- INIT state:
  - The memory self-clears one slot per clk for NSLOTS clks after reset and ignores writes meanwhile.
  - init_cnt counts every clk edge, independent of clkena.
  - memwr is held 0 throughout INIT.
  - When init_cnt reaches NSLOTS-1, the next edge enters RUN with slot_out=0, stage=RD.
- RUN state: two clkena-qualified steps per slot, so a frame is 2*NSLOTS enabled steps.
  - RD step: slot_out=S, memwr=0. The memory registers phase[S] at this edge, so memrdata is valid in the following WR step.
  - WR step: slot_out stays S. Combinationally, memwr = clkena and memwdata = next. The memory captures the write at the end of the WR cycle.
  - At that same edge: pgout <= next[PHASE_W-1 -: PG_W], pg_slot <= S, pg_valid <= 1, and slot_out advances to S+1 (or 0 if S=NSLOTS-1), stage <= RD.
  - pg_valid is 0 on every other edge.
- Increment computation:
  - mul2 table indexed by ml 0..15: 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30 (twice the multiple; ml=0 gives x0.5).
  - incr = ((fnum << blk) * mul2) >> 1, computed at 21 bits before the shift, then truncated to PHASE_W.
  - next = key_trig ? 0 : (memrdata + incr) mod 2^PHASE_W. Wrap-around is silent.
- clkena=0 in RUN:
  - All registers hold and memwr=0.
  - slot_out stays stable, so the memory re-reads the same slot; memrdata remains valid for a held WR step.
- clkena toggling never splits an RD/WR pair across slots.

Test Plan:
- Reset then clkena=1: memwr=0 for the first 18 clks; first RD uses slot_out=0; first write targets slot 0 at step 2 of RUN.
- fnum=256, blk=2, ml=1 on all slots: frame 1 writes 1024 to each slot with pgout=2; frame 2 writes 2048 with pgout=4; pg_slot cycles 0..17 then wraps to 0.
- ml=0, fnum=3, blk=0: frame 1 writes 1, frame 2 writes 2 (x0.5 multiple and truncation verified).
- fnum=511, blk=7, ml=15 from phase 0: writes 194688 (981120 mod 262144); the next frame writes 127232 (wrap).
- key_trig=1 during slot 5's WR step after several frames: slot 5 is written 0 with pgout=0; other slots are unaffected.
- clkena low for 7 clks mid-WR step, then reset asserted mid-frame:
  - During the stall: memwr=0 and slot_out held; after release, a single write lands with the correct value.
  - On reset: outputs return to reset values immediately, and INIT lasts another 18 clks.
